line_buffer_pp: RTL and testbench
=================================

LINE_BUFFER_PP -- requirements
Module: line_buffer_pp

Interface
REQ-001 Parameters: HACTIVE = 256, active pixels per line; VTOTAL = 288, last vc value before wrap; TRANSP = 4'hF, transparent pen code.
REQ-002 Ports: clk  in  1  system clock, the only clock. reset  in  1  synchronous, active-high. clk_pix  in  1  pixel clock-enable, one clk cycle wide.
REQ-003 Ports: hc  in  9  horizontal count. vc  in  9  vertical count. hbl  in  1  horizontal blank. vbl  in  1  vertical blank.
REQ-004 Ports: line_start  out  1  one-clk pulse at bank swap. line_num  out  9  line to render into the write bank.
REQ-005 Ports: wr_en  in  1  write request. wr_x  in  9  x position. wr_data  in  8  {palette[3:0], pen[3:0]}. wr_ready  out  1  write accepted this cycle.
REQ-006 Ports: pix_out  out  8  display pixel. pix_opaque  out  1  pix_out[3:0] != TRANSP.

Function
REQ-007 The block SHALL hold two 256x8 banks: one display bank read by video, one write bank filled by the sprite engine; roles swap each line.
REQ-008 Swap SHALL occur on the clk cycle where clk_pix=1 and hbl falls (registered hbl=1, input hbl=0). In the same cycle line_start=1 and line_num <= (vc==VTOTAL) ? 0 : vc+1.
REQ-009 A write request SHALL be accepted when wr_en=1 and wr_ready=1; wr_x >= HACTIVE or wr_data[3:0]==TRANSP SHALL be accepted and discarded.
REQ-010 Accepted writes SHALL use a 2-stage pipeline: S1 reads the existing entry at wr_x; S2 writes wr_data only if the existing pen == TRANSP (first writer wins).
REQ-011 Hazard: if S2 writes address A while S1 reads A, S1 SHALL treat the entry as opaque (forwarded); back-to-back writes to one x keep the first.
REQ-012 wr_ready SHALL be 0 on the swap cycle and the following 2 clk cycles; in-flight writes SHALL complete to the bank they were issued against.
REQ-013 Readout: on clk_pix=1 with hbl=0, the display bank SHALL be read at hc[7:0]; pix_out SHALL be registered 1 clk later and held until the next clk_pix.
REQ-014 Read-clear: the clk after each readout, the address just read SHALL be written with 8'h0F, so the bank is transparent when it becomes the write bank.
REQ-015 While hbl=1, pix_out SHALL be 8'h0F. vbl does not gate swapping or clearing.
REQ-016 Simultaneous sprite write and clear target different banks and SHALL both proceed in the same cycle.

Reset
REQ-017 During reset: pix_out=8'h0F, pix_opaque=0, line_start=0, line_num=0, wr_ready=0, bank select=0, pipeline valids cleared.
REQ-018 After reset release, an FSM SHALL step CLEAR -> RUN. CLEAR writes 8'h0F to all 256 addresses of both banks (256 clk), with wr_ready=0, swaps ignored and pix_out=8'h0F.
REQ-019 Reset asserted mid-line or mid-CLEAR SHALL abort and restart CLEAR from address 0 on release.

Structure
REQ-020 A shared package SHALL hold HACTIVE, VTOTAL, TRANSP, CLEAR_VAL = 8'h0F and the FSM state enum {CLEAR, RUN}.
REQ-021 One sub-module, lb_bank_ram (256x8, one synchronous read port and one write port), SHALL be instantiated twice; the port muxes are selected by the bank-select bit.

Verification
REQ-022 Reset release -> wr_ready=0 for exactly 256 clk, then 1; a full-line readout then gives pix_out=8'h0F and pix_opaque=0 for all x.
REQ-023 Write x=10 data 8'h23, then x=10 data 8'h45 back-to-back; after the swap, readout at hc=10 gives 8'h23 and hc=11 gives 8'h0F.
REQ-024 Write x=300 data 8'h12 and x=5 data 8'h1F -> both accepted; the next displayed line is all 8'h0F.
REQ-025 Fill all 256 x with 8'h51, display the line, let it swap back without writes -> the second display pass is all 8'h0F (clear verified).
REQ-026 vc=288 at swap -> line_num=0 with a one-clk line_start pulse; vc=100 -> line_num=101.
REQ-027 Assert reset at hc=128 mid-readout -> outputs reach reset values; CLEAR restarts and lasts 256 clk.

Source files
------------

// File: rtl/line_buffer_pp_pkg.sv
// rtl/line_buffer_pp_pkg.sv - shared constants and state type for the ping-pong line buffer
// Purpose: geometry, transparent pen code, clear value and controller states.
// Ports: none (package).
package line_buffer_pp_pkg;

    localparam int         HACTIVE   = 256;
    localparam logic [8:0] VTOTAL    = 9'd288;
    localparam logic [3:0] TRANSP    = 4'hF;
    localparam logic [7:0] CLEAR_VAL = 8'h0F;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } lb_state_t;

endpackage

// File: rtl/line_buffer_pp_if.sv
// rtl/line_buffer_pp_if.sv - sprite-engine write port of the line buffer
// Purpose: bundles the write request handshake.
// Ports: wr_en/wr_x/wr_data driven by the sprite engine (master), wr_ready by the buffer (slave).
interface line_buffer_pp_if;

    logic       wr_en;
    logic [8:0] wr_x;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_en, output wr_x, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_x, input wr_data, output wr_ready);

endinterface

// File: rtl/line_buffer_pp_ram.sv
// rtl/line_buffer_pp_ram.sv - 256x8 line bank, one synchronous read port and one write port
// Purpose: storage for one line of sprite pixels.
// Ports: clk; i_rd_addr -> o_rd_data one clk later; i_wr_en/i_wr_addr/i_wr_data write port.
module lb_bank_ram (
    input  logic       clk,
    input  logic [7:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_addr,
    input  logic [7:0] i_wr_data
);

    logic [7:0] r_mem [256];

    // A read of the address being written returns the old contents.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/line_buffer_pp.sv
// rtl/line_buffer_pp.sv - ping-pong sprite line buffer with first-writer-wins and read-clear
// Purpose: video reads the display bank while the sprite engine fills the write bank;
//          banks swap at the falling edge of horizontal blank.
// Ports: clk, reset (sync, active-high), clk_pix (pixel enable), hc/vc/hbl/vbl (video timing),
//        line_start/line_num (render request for the new write bank), wr (sprite write port),
//        pix_out/pix_opaque (display pixel).
module line_buffer_pp
    import line_buffer_pp_pkg::lb_state_t, line_buffer_pp_pkg::CLEAR,
           line_buffer_pp_pkg::RUN, line_buffer_pp_pkg::CLEAR_VAL;
#(
    parameter int         HACTIVE = line_buffer_pp_pkg::HACTIVE,
    parameter logic [8:0] VTOTAL  = line_buffer_pp_pkg::VTOTAL,
    parameter logic [3:0] TRANSP  = line_buffer_pp_pkg::TRANSP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_pix,
    input  logic [8:0]              hc,
    input  logic [8:0]              vc,
    input  logic                    hbl,
    input  logic                    vbl,
    output logic                    line_start,
    output logic [8:0]              line_num,
    line_buffer_pp_if.slave         wr,
    output logic [7:0]              pix_out,
    output logic                    pix_opaque
);

    localparam logic [9:0] X_LIMIT = 10'(HACTIVE);

    lb_state_t  r_state;
    logic [7:0] r_clr_addr;
    logic       r_hbl;
    logic       r_bank_sel;     // bank currently on display
    logic [1:0] r_blk;          // write-block cycles remaining after a swap
    logic       r_s2_valid;
    logic       r_s2_fwd;
    logic       r_s2_bank;
    logic [7:0] r_s2_addr;
    logic [7:0] r_s2_data;
    logic       r_rd_pend;
    logic       r_rd_bank;
    logic [7:0] r_rd_addr;
    logic [7:0] r_pix;
    logic [8:0] r_line_num;
    logic       r_line_start;

    logic       w_run;
    logic       w_swap;
    logic       w_disp_sel;
    logic       w_readout;
    logic       w_ready;
    logic       w_s1_go;
    logic [7:0] w_s2_old;
    logic       w_s2_we;
    logic [7:0] w_rd_data [2];
    logic       w_unused;

    assign w_run      = (r_state == RUN);
    assign w_swap     = w_run && clk_pix && r_hbl && !hbl;
    // On the swap cycle the first pixel must already come from the incoming display bank.
    assign w_disp_sel = r_bank_sel ^ w_swap;
    assign w_readout  = w_run && clk_pix && !hbl;
    assign w_ready    = w_run && !reset && !w_swap && (r_blk == 2'd0);

    // Off-line or transparent writes are accepted but never enter the pipeline.
    assign w_s1_go  = wr.wr_en && w_ready && ({1'b0, wr.wr_x} < X_LIMIT)
                      && (wr.wr_data[3:0] != TRANSP);
    assign w_s2_old = w_rd_data[r_s2_bank];
    assign w_s2_we  = r_s2_valid && !r_s2_fwd && (w_s2_old[3:0] == TRANSP);

    assign wr.wr_ready = w_ready;
    assign line_start  = r_line_start;
    assign line_num    = r_line_num;
    assign pix_out     = r_pix;
    assign pix_opaque  = (r_pix[3:0] != TRANSP);
    assign w_unused    = ^{vbl, hc[8]};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [7:0] w_rd_addr;
        logic       w_we;
        logic [7:0] w_wa;
        logic [7:0] w_wd;

        // Display bank is read at hc, write bank at the sprite x. Clearing and sprite
        // writes always land in opposite banks, so each bank sees at most one writer.
        always_comb begin
            w_rd_addr = (w_disp_sel == 1'(b)) ? hc[7:0] : wr.wr_x[7:0];
            w_we      = 1'b0;
            w_wa      = r_s2_addr;
            w_wd      = r_s2_data;
            if (!w_run) begin
                w_we = 1'b1;
                w_wa = r_clr_addr;
                w_wd = CLEAR_VAL;
            end else if (r_rd_pend && (r_rd_bank == 1'(b))) begin
                w_we = 1'b1;
                w_wa = r_rd_addr;
                w_wd = CLEAR_VAL;
            end else if (w_s2_we && (r_s2_bank == 1'(b))) begin
                w_we = 1'b1;
            end
        end

        lb_bank_ram u_ram (
            .clk       (clk),
            .i_rd_addr (w_rd_addr),
            .o_rd_data (w_rd_data[b]),
            .i_wr_en   (w_we),
            .i_wr_addr (w_wa),
            .i_wr_data (w_wd)
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= CLEAR;
            r_clr_addr   <= 8'd0;
            r_hbl        <= 1'b0;
            r_bank_sel   <= 1'b0;
            r_blk        <= 2'd0;
            r_s2_valid   <= 1'b0;
            r_s2_fwd     <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_pix        <= CLEAR_VAL;
            r_line_num   <= 9'd0;
            r_line_start <= 1'b0;
        end else begin
            if (clk_pix) begin
                r_hbl <= hbl;
            end
            if (!w_run) begin
                r_clr_addr <= r_clr_addr + 8'd1;
                if (r_clr_addr == 8'hFF) begin
                    r_state <= RUN;
                end
            end
            r_line_start <= w_swap;
            if (w_swap) begin
                r_bank_sel <= ~r_bank_sel;
                r_blk      <= 2'd2;
                r_line_num <= (vc == VTOTAL) ? 9'd0 : vc + 9'd1;
            end else if (r_blk != 2'd0) begin
                r_blk <= r_blk - 2'd1;
            end
            r_s2_valid <= w_s1_go;
            // The RAM returns pre-write data when S1 reads what S2 is writing, so the
            // entry is forced opaque for the younger request.
            r_s2_fwd   <= w_s2_we && (r_s2_addr == wr.wr_x[7:0]);
            r_rd_pend  <= w_readout;
            if (!w_run || (clk_pix && hbl)) begin
                r_pix <= CLEAR_VAL;
            end else if (r_rd_pend) begin
                r_pix <= w_rd_data[r_rd_bank];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_go) begin
            r_s2_addr <= wr.wr_x[7:0];
            r_s2_data <= wr.wr_data;
            r_s2_bank <= ~r_bank_sel;
        end
        if (w_readout) begin
            r_rd_addr <= hc[7:0];
            r_rd_bank <= w_disp_sel;
        end
    end

endmodule

// File: tb/tb_line_buffer_pp.sv
// tb/tb_line_buffer_pp.sv - scoreboard bench for the ping-pong line buffer
module tb_line_buffer_pp;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_pix;
    logic [8:0] hc;
    logic [8:0] vc;
    logic       hbl;
    logic       vbl;
    logic       line_start;
    logic [8:0] line_num;
    logic [7:0] pix_out;
    logic       pix_opaque;

    line_buffer_pp_if wr_if ();

    line_buffer_pp u_dut (
        .clk        (clk),
        .reset      (reset),
        .clk_pix    (clk_pix),
        .hc         (hc),
        .vc         (vc),
        .hbl        (hbl),
        .vbl        (vbl),
        .line_start (line_start),
        .line_num   (line_num),
        .wr         (wr_if),
        .pix_out    (pix_out),
        .pix_opaque (pix_opaque)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] d;
    } wreq_t;

    int         n_chk = 0;
    int         n_pass = 0;
    int         acc_cnt = 0;
    logic [7:0] exp_q [$];
    wreq_t      wq [$];
    bit         wr_go = 1'b0;
    bit         chk_line = 1'b0;
    bit         rd_d1 = 1'b0;
    bit         rd_d2 = 1'b0;
    logic       ls0, ls1;
    logic [8:0] ln0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a checked readout at cycle t appears on pix_out from cycle t+2.
    always @(negedge clk) begin
        logic [7:0] mexp;
        if (rd_d2) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_underflow: pixel %0h with no expected value", pix_out);
            end else begin
                mexp = exp_q.pop_front();
                check("pix_out", {24'd0, pix_out}, {24'd0, mexp});
                check("pix_opaque", {31'd0, pix_opaque}, {31'd0, (mexp[3:0] != 4'hF)});
            end
        end
        rd_d2 = rd_d1;
        rd_d1 = clk_pix && !hbl && chk_line && !reset;
    end

    // Sprite-engine model: presents the queue head while enabled, pops on acceptance.
    initial begin
        wr_if.wr_en   = 1'b0;
        wr_if.wr_x    = 9'd0;
        wr_if.wr_data = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (wr_go && wq.size() > 0) begin
                wr_if.wr_en   = 1'b1;
                wr_if.wr_x    = wq[0].x;
                wr_if.wr_data = wq[0].d;
            end else begin
                wr_if.wr_en = 1'b0;
            end
            @(negedge clk);
            if (wr_if.wr_en && wr_if.wr_ready) begin
                void'(wq.pop_front());
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic blank_pix(input int n);
        for (int i = 0; i < n; i++) begin
            hbl = 1'b1; hc = 9'd300; clk_pix = 1'b1;
            tick();
            clk_pix = 1'b0;
            tick();
        end
    endtask

    task automatic push_wr(input logic [8:0] x, input logic [7:0] d);
        wq.push_back({x, d});
    endtask

    task automatic push_line(input logic [7:0] fill, input int sx, input logic [7:0] sv);
        for (int i = 0; i < 256; i++) exp_q.push_back((i == sx) ? sv : fill);
    endtask

    // One line: 256 active pixels then 16 blank, clk_pix every other clk.
    task automatic run_line(input logic [8:0] v, input bit chk, input int abort_at);
        vc = v;
        for (int h = 0; h < 272; h++) begin
            if (h == abort_at) begin
                reset = 1'b1; chk_line = 1'b0; wr_go = 1'b0; clk_pix = 1'b0;
                return;
            end
            hbl = (h >= 256); hc = 9'(h); chk_line = chk && (h < 256); clk_pix = 1'b1;
            tick();
            if (h == 0) begin
                ls0 = line_start; ln0 = line_num; wr_go = 1'b1;
            end
            clk_pix = 1'b0;
            tick();
            if (h == 0) ls1 = line_start;
        end
        chk_line = 1'b0;
        wr_go = 1'b0;
    endtask

    task automatic count_clear(input string name);
        int n = 0;
        while (!wr_if.wr_ready && n < 1000) begin
            tick();
            n++;
        end
        check(name, n, 256);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pix_out"}, {24'd0, pix_out}, 32'h0F);
        check({tag, "_pix_opaque"}, {31'd0, pix_opaque}, 32'd0);
        check({tag, "_line_start"}, {31'd0, line_start}, 32'd0);
        check({tag, "_line_num"}, {23'd0, line_num}, 32'd0);
        check({tag, "_wr_ready"}, {31'd0, wr_if.wr_ready}, 32'd0);
    endtask

    initial begin
        int acc0;
        reset = 1'b1; clk_pix = 1'b0; hbl = 1'b1; vbl = 1'b0; hc = 9'd0; vc = 9'd0;
        repeat (3) tick();
        check_reset_vals("rst");
        reset = 1'b0;
        count_clear("clear_len_after_reset");
        blank_pix(4);

        // Line 1: cleared banks display transparent; queue same-x back-to-back writes.
        push_line(8'h0F, -1, 8'h00);
        push_wr(9'd10, 8'h23);
        push_wr(9'd10, 8'h45);
        run_line(9'd100, 1'b1, -1);
        check("line_start_pulse", {31'd0, ls0}, 32'd1);
        check("line_start_width", {31'd0, ls1}, 32'd0);
        check("line_num_vc100", {23'd0, ln0}, 32'd101);
        check("wq_drained_l1", wq.size(), 0);

        // Line 2: first writer wins at x=10; off-line and transparent writes queued.
        push_line(8'h0F, 10, 8'h23);
        push_wr(9'd300, 8'h12);
        push_wr(9'd5, 8'h1F);
        acc0 = acc_cnt;
        run_line(9'd288, 1'b1, -1);
        check("line_num_vtotal_wrap", {23'd0, ln0}, 32'd0);
        check("line_start_pulse_wrap", {31'd0, ls0}, 32'd1);
        check("discarded_writes_accepted", acc_cnt - acc0, 2);

        // Line 3: discarded writes left nothing; fill the whole write bank.
        push_line(8'h0F, -1, 8'h00);
        for (int x = 0; x < 256; x++) push_wr(9'(x), 8'h51);
        run_line(9'd5, 1'b1, -1);
        check("wq_drained_fill", wq.size(), 0);

        // Line 4 shows the fill; lines 5 and 6 prove both banks were read-cleared.
        push_line(8'h51, -1, 8'h00);
        run_line(9'd6, 1'b1, -1);
        push_line(8'h0F, -1, 8'h00);
        run_line(9'd7, 1'b1, -1);
        push_line(8'h0F, -1, 8'h00);
        run_line(9'd8, 1'b1, -1);

        // Load a bank with 8'h62, display it and reset half way through the line.
        for (int x = 0; x < 256; x++) push_wr(9'(x), 8'h62);
        run_line(9'd9, 1'b0, -1);
        check("wq_drained_62", wq.size(), 0);
        run_line(9'd10, 1'b0, 128);
        hbl = 1'b1;
        tick();
        check_reset_vals("midline");
        tick();
        reset = 1'b0;
        repeat (100) tick();
        reset = 1'b1;
        tick();
        check("wr_ready_midclear_reset", {31'd0, wr_if.wr_ready}, 32'd0);
        reset = 1'b0;
        count_clear("clear_len_restart");
        blank_pix(4);
        push_line(8'h0F, -1, 8'h00);
        run_line(9'd11, 1'b1, -1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
